// File: rtl/rf_bypass_sb_pkg.sv
// Shared defaults and index types for the
// bypassing register file and its scoreboard.
package rf_bypass_sb_pkg;
  localparam int XLEN_D = 32;
  localparam int NREG_D = 32;
  localparam int AW_D = $clog2(NREG_D);
  localparam logic [AW_D-1:0] REG_ZERO = '0;
  typedef logic [AW_D-1:0] reg_idx_t;
endpackage

// File: rtl/rf_bypass_sb_scoreboard.sv
// Pending-producer scoreboard: set on issue,
// clear on writeback, wipe on flush.
module rf_scoreboard
  import rf_bypass_sb_pkg::*;
#(
  parameter int NREG = NREG_D,
  parameter int BYPASS = 1,
  parameter int ZERO_REG = 1,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rR1,
  input  logic [AW-1:0]   rR2,
  input  logic            we,
  input  logic [AW-1:0]   wR,
  input  logic            issue,
  input  logic [AW-1:0]   issue_rd,
  input  logic            flush,
  output logic            busy1,
  output logic            busy2,
  output logic [NREG-1:0] pending
);

  logic [NREG-1:0] p;
  logic [NREG-1:0] set_v;
  logic [NREG-1:0] clr_v;
  logic            iss_ok;
  logic            fwd1;
  logic            fwd2;

  assign iss_ok = issue &&
    !(ZERO_REG != 0 && issue_rd == AW'(REG_ZERO));

  always_comb begin
    set_v = '0;
    clr_v = '0;
    if (iss_ok) set_v[issue_rd] = 1'b1;
    if (we) clr_v[wR] = 1'b1;
  end

  // set beats clear: the issuing producer is younger
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p <= '0;
    end else if (flush) begin
      p <= '0;
    end else begin
      p <= set_v | (p & ~clr_v);
    end
  end

  assign fwd1 = (BYPASS != 0) && we && wR == rR1 &&
    !(issue && issue_rd == rR1);
  assign fwd2 = (BYPASS != 0) && we && wR == rR2 &&
    !(issue && issue_rd == rR2);

  assign busy1 = p[rR1] & ~fwd1;
  assign busy2 = p[rR2] & ~fwd2;
  assign pending = p;

endmodule

// File: rtl/rf_bypass_sb.sv
// Two-read, one-write register file with
// write-to-read bypass and pending scoreboard.
module rf_bypass_sb
  import rf_bypass_sb_pkg::*;
#(
  parameter int XLEN = XLEN_D,
  parameter int NREG = NREG_D,
  parameter int BYPASS = 1,
  parameter int ZERO_REG = 1,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rR1,
  input  logic [AW-1:0]   rR2,
  output logic [XLEN-1:0] rD1,
  output logic [XLEN-1:0] rD2,
  output logic            busy1,
  output logic            busy2,
  input  logic            we,
  input  logic [AW-1:0]   wR,
  input  logic [XLEN-1:0] wD,
  input  logic            issue,
  input  logic [AW-1:0]   issue_rd,
  input  logic            flush,
  output logic [NREG-1:0] pending
);

  logic [XLEN-1:0] regs [NREG];
  logic            wr_ok;

  assign wr_ok = we &&
    !(ZERO_REG != 0 && wR == AW'(REG_ZERO));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wR] <= wD;
    end
  end

  always_comb begin
    rD1 = regs[rR1];
    if (BYPASS != 0 && we && rR1 == wR) rD1 = wD;
    if (ZERO_REG != 0 && rR1 == AW'(REG_ZERO)) rD1 = '0;
  end

  always_comb begin
    rD2 = regs[rR2];
    if (BYPASS != 0 && we && rR2 == wR) rD2 = wD;
    if (ZERO_REG != 0 && rR2 == AW'(REG_ZERO)) rD2 = '0;
  end

  rf_scoreboard #(
    .NREG(NREG),
    .BYPASS(BYPASS),
    .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clk(clk),
    .rst(rst),
    .rR1(rR1),
    .rR2(rR2),
    .we(we),
    .wR(wR),
    .issue(issue),
    .issue_rd(issue_rd),
    .flush(flush),
    .busy1(busy1),
    .busy2(busy2),
    .pending(pending)
  );

endmodule

// File: tb/tb_rf_bypass_sb.sv
// Scoreboard bench: stimulus queues expectations,
// a negedge monitor pops and compares them.
module tb_rf_bypass_sb;
  import rf_bypass_sb_pkg::*;

  localparam int S_RD1 = 0;
  localparam int S_RD2 = 1;
  localparam int S_BUSY1 = 2;
  localparam int S_BUSY2 = 3;
  localparam int S_PEND = 4;
  localparam int S_NRD1 = 5;
  localparam int S_NBUSY1 = 6;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  logic        clk;
  logic        rst;
  reg_idx_t    rR1, rR2, wR, issue_rd;
  logic [31:0] wD;
  logic        we, issue, flush;
  logic [31:0] rD1, rD2, nD1, nD2;
  logic        busy1, busy2, nb1, nb2;
  logic [31:0] pending, npend;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  rf_bypass_sb dut (
    .clk(clk), .rst(rst),
    .rR1(rR1), .rR2(rR2),
    .rD1(rD1), .rD2(rD2),
    .busy1(busy1), .busy2(busy2),
    .we(we), .wR(wR), .wD(wD),
    .issue(issue), .issue_rd(issue_rd),
    .flush(flush), .pending(pending)
  );

  rf_bypass_sb #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst),
    .rR1(rR1), .rR2(rR2),
    .rD1(nD1), .rD2(nD2),
    .busy1(nb1), .busy2(nb2),
    .we(we), .wR(wR), .wD(wD),
    .issue(issue), .issue_rd(issue_rd),
    .flush(flush), .pending(npend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pick(int s);
    case (s)
      S_RD1:    return rD1;
      S_RD2:    return rD2;
      S_BUSY1:  return {31'd0, busy1};
      S_BUSY2:  return {31'd0, busy2};
      S_PEND:   return pending;
      S_NRD1:   return nD1;
      default:  return {31'd0, nb1};
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    logic [31:0] act;
    while (q.size() > 0) begin
      e = q.pop_front();
      act = pick(e.sel);
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s: got %h want %h",
                 e.name, act, e.exp);
      end
    end
  end

  task automatic chk(string n, int s, logic [31:0] v);
    exp_t e;
    e.name = n;
    e.sel = s;
    e.exp = v;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    rR1 = '0; rR2 = '0; wR = '0; issue_rd = '0;
    wD = '0; we = 1'b0; issue = 1'b0; flush = 1'b0;
    step();
    step();
    rst = 1'b0;
    rR1 = 5'd3;
    chk("reset_rd1", S_RD1, 32'h0);
    chk("reset_busy1", S_BUSY1, 32'h0);
    chk("reset_pend", S_PEND, 32'h0);

    for (int i = 1; i < 32; i++) begin
      step();
      we = 1'b1;
      wR = reg_idx_t'(i);
      wD = 32'hA5A5_0000 + 32'(i);
      rR1 = reg_idx_t'(i);
      chk("fill_byp", S_RD1, 32'hA5A5_0000 + 32'(i));
      chk("fill_nobyp", S_NRD1, 32'h0);
    end
    step();
    we = 1'b0;
    rR1 = 5'd1;
    rR2 = 5'd31;
    chk("fill_rd1", S_RD1, 32'hA5A5_0001);
    chk("fill_rd2", S_RD2, 32'hA5A5_001F);

    step();
    rst = 1'b1;
    chk("arst_rd1", S_RD1, 32'h0);
    chk("arst_rd2", S_RD2, 32'h0);
    chk("arst_pend", S_PEND, 32'h0);
    for (int i = 0; i < 16; i++) begin
      step();
      rR1 = reg_idx_t'(2 * i);
      rR2 = reg_idx_t'(2 * i + 1);
      chk("rst_rd1", S_RD1, 32'h0);
      chk("rst_rd2", S_RD2, 32'h0);
    end
    step();
    rst = 1'b0;

    step();
    we = 1'b1; wR = 5'd0; wD = 32'hDEAD_BEEF;
    issue = 1'b1; issue_rd = 5'd0; rR1 = 5'd0;
    chk("x0_rd1", S_RD1, 32'h0);
    chk("x0_busy1", S_BUSY1, 32'h0);
    step();
    we = 1'b0; issue = 1'b0;
    chk("x0_pend", S_PEND, 32'h0);
    chk("x0_rd1_after", S_RD1, 32'h0);

    step();
    we = 1'b1; wR = 5'd5; wD = 32'h11;
    step();
    wD = 32'h22; rR1 = 5'd5;
    chk("byp_rd1", S_RD1, 32'h22);
    chk("nobyp_rd1", S_NRD1, 32'h11);
    step();
    we = 1'b0;
    chk("byp_rd1_next", S_RD1, 32'h22);
    chk("nobyp_rd1_next", S_NRD1, 32'h22);

    step();
    issue = 1'b1; issue_rd = 5'd7; rR1 = 5'd7;
    chk("sb_c0_busy", S_BUSY1, 32'h0);
    step();
    issue = 1'b0;
    chk("sb_c1_busy", S_BUSY1, 32'h1);
    chk("sb_c1_pend", S_PEND, 32'h80);
    step();
    chk("sb_c2_busy", S_BUSY1, 32'h1);
    step();
    we = 1'b1; wR = 5'd7; wD = 32'h77;
    chk("sb_c3_busy", S_BUSY1, 32'h0);
    chk("sb_c3_nobyp_busy", S_NBUSY1, 32'h1);
    chk("sb_c3_rd1", S_RD1, 32'h77);
    chk("sb_c3_pend", S_PEND, 32'h80);
    step();
    we = 1'b0;
    chk("sb_c4_pend", S_PEND, 32'h0);
    chk("sb_c4_busy", S_BUSY1, 32'h0);

    step();
    issue = 1'b1; issue_rd = 5'd9;
    step();
    issue = 1'b1; issue_rd = 5'd9;
    we = 1'b1; wR = 5'd9; wD = 32'h99; rR1 = 5'd9;
    chk("col_pend_pre", S_PEND, 32'h200);
    chk("col_busy", S_BUSY1, 32'h1);
    chk("col_rd1", S_RD1, 32'h99);
    step();
    issue = 1'b0; we = 1'b0;
    chk("col_pend_post", S_PEND, 32'h200);
    chk("col_rd1_post", S_RD1, 32'h99);
    step();
    we = 1'b1; wR = 5'd9; wD = 32'h9A;
    step();
    we = 1'b0;
    chk("col_clear", S_PEND, 32'h0);

    step();
    issue = 1'b1; issue_rd = 5'd3;
    step();
    issue_rd = 5'd4;
    step();
    flush = 1'b1; issue = 1'b1; issue_rd = 5'd6;
    rR1 = 5'd3; rR2 = 5'd4;
    chk("fl_pend_pre", S_PEND, 32'h18);
    chk("fl_busy1", S_BUSY1, 32'h1);
    chk("fl_busy2", S_BUSY2, 32'h1);
    step();
    flush = 1'b0; issue = 1'b0;
    chk("fl_pend_post", S_PEND, 32'h0);
    chk("fl_busy2_post", S_BUSY2, 32'h0);
    step();
    we = 1'b1; wR = 5'd3; wD = 32'h33;
    chk("fl_wb_busy", S_BUSY1, 32'h0);
    step();
    we = 1'b0;
    chk("fl_wb_pend", S_PEND, 32'h0);
    chk("fl_wb_rd1", S_RD1, 32'h33);

    step();
    for (int k = 0; k < 10 && q.size() > 0; k++)
      @(negedge clk);
    #1;
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain: left %0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
